game_session_ctrl: RTL
======================

// Module: game_session_ctrl
// PURPOSE
//  Session sequencer in front of ingameFSM: debounces raw KEYs, drives inGameOn/userquit/select1/select2.
//  Holds the compare press in TwoTile for a reveal window so both tiles stay visible before FSM clears them.
//  Also handles start/quit, game-over handoff, idle timeout and a games-played count; sits between board KEYs and ingameFSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000      stable-low cycles before a KEY press is accepted (20 ms @50 MHz)
//  REVEAL_CYCLES    99_999_999     cycles compare press is held in TwoTile (2 s, matches clock_twosec_counter)
//  IDLE_CYCLES      1_500_000_000  cycles without accepted press in play before forced quit (30 s)
//  PULSE_CYCLES     2              low-pulse length of forwarded select1/select2
// PORTS
//  CLOCK_50        in   1  system clock, 50 MHz
//  clear           in   1  asynchronous, active-low reset
//  key_start_n     in   1  raw start KEY, active-low
//  key_quit_n      in   1  raw quit KEY, active-low
//  key_sel1_n      in   1  raw select1/compare KEY, active-low
//  key_sel2_n      in   1  raw select2 KEY, active-low
//  gameOver        in   1  from ingameFSM
//  inGameState     in   3  currentInGameState from ingameFSM (TwoTile = 3'b011)
//  inGameOn        out  1  enables ingameFSM
//  userquit        out  1  one-cycle quit pulse to ingameFSM
//  select1,select2 out  1  conditioned active-low selects to ingameFSM (idle high)
//  reveal_busy     out  1  high in S_HOLD/S_FIRE
//  games_played    out  8  completed games, saturates at 255
//  sessionState    out  3  controller state, debug
// BEHAVIOUR
//  Reset (clear=0, async): S_OFF; inGameOn=0, userquit=0, select1=select2=1, reveal_busy=0, games_played=0, all counters cleared.
//  Debounce: press accepted once input low for DEBOUNCE_CYCLES consecutive cycles; yields one-cycle press strobe; re-arms only after
//   input high for DEBOUNCE_CYCLES. Strobe latency = DEBOUNCE_CYCLES+2 cycles after the falling edge (2-flop synchroniser).
//  States: S_OFF=0, S_PLAY=1, S_HOLD=2, S_FIRE=3, S_DONE=4.
//  S_OFF : inGameOn=0. start strobe -> S_PLAY, inGameOn=1 next cycle. Other strobes ignored.
//  S_PLAY: inGameOn=1. sel2 strobe -> select2 low PULSE_CYCLES cycles. sel1 strobe with inGameState!=TwoTile -> select1 low
//   PULSE_CYCLES cycles. sel1 strobe with inGameState==TwoTile -> S_HOLD, load reveal counter = REVEAL_CYCLES-1, no pulse.
//   gameOver=1 -> S_DONE, inGameOn=0, games_played+1 (saturating). Idle counter resets on any accepted strobe; reaching
//   IDLE_CYCLES acts as quit.
//  S_HOLD: reveal counter decrements; sel strobes dropped; at 0 -> S_FIRE.
//  S_FIRE: select1 low PULSE_CYCLES cycles, then S_PLAY.
//  S_DONE: inGameOn=0 (ingameFSM parks in OffGameOver); start strobe -> S_PLAY, inGameOn=1.
//  Quit (strobe or idle timeout) in PLAY/HOLD/FIRE: userquit=1 for exactly one cycle, inGameOn=0, select1/select2 forced
//   high, -> S_OFF, counters cleared. Quit in OFF/DONE ignored.
//  Priority same cycle: quit > gameOver > sel1 > sel2 (sel2 dropped, not queued); start ignored outside OFF/DONE.
//  A new select pulse never starts while one is in progress; strobes arriving then are dropped.
//  Reset mid-pulse or mid-hold: outputs return to reset values immediately; no pending pulse survives.
// STRUCTURE
//  game_pkg: controller state encodings, ingameFSM state encodings (Idle 000, OneTile 001, TwoTile 011,
//   OffGameOver 100, NotInGame 101), default cycle constants.
//  Sub-module key_debounce (parameter DEBOUNCE_CYCLES; CLOCK_50, clear, key_n -> press strobe), instanced four times.
//  Counter widths via $clog2 of each parameter.
// TESTING  (DEBOUNCE_CYCLES=4, REVEAL_CYCLES=10, IDLE_CYCLES=60, PULSE_CYCLES=2)
//  Reset mid-S_HOLD -> same cycle inGameOn=0, reveal_busy=0, select1=1, sessionState=0, games_played=0.
//  key_start_n low 3 cycles then high (bounce) -> no strobe, stays S_OFF; low 6 cycles -> S_PLAY, inGameOn=1.
//  In PLAY, inGameState=001, sel2 press -> select2 low exactly 2 cycles, ~DEBOUNCE+2 cycles after edge.
//  inGameState=011, sel1 press -> no select1 pulse for 10 cycles, reveal_busy=1, then select1 low 2 cycles, back to S_PLAY.
//  sel1 and quit strobes same cycle in PLAY -> userquit one cycle, S_OFF, no select pulse; no presses 60 cycles -> same.
//  gameOver=1 in PLAY, 256 times -> S_DONE, inGameOn=0, games_played saturates at 255; start -> S_PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and default timing constants for the game session controller.
package game_pkg;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_FIRE = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // ingameFSM currentInGameState encodings
  localparam logic [2:0] IG_IDLE          = 3'b000;
  localparam logic [2:0] IG_ONE_TILE      = 3'b001;
  localparam logic [2:0] IG_TWO_TILE      = 3'b011;
  localparam logic [2:0] IG_OFF_GAME_OVER = 3'b100;
  localparam logic [2:0] IG_NOT_IN_GAME   = 3'b101;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REVEAL_CYCLES   = 99_999_999;
  localparam int unsigned DEF_IDLE_CYCLES     = 1_500_000_000;
  localparam int unsigned DEF_PULSE_CYCLES    = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low KEY and emits a one-cycle strobe once a press is stable.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic CLOCK_50,
  input  logic clear,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q, stable_q, press_q;
  logic [CW-1:0] cnt_q;

  // stable_q only follows sync2_q after it has differed for DEBOUNCE_CYCLES cycles in a row,
  // so the release also has to be stable before another press can be accepted.
  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
        press_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer between the board KEYs and ingameFSM: start/quit, reveal hold,
// select pulse shaping, idle timeout and games-played count.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REVEAL_CYCLES   = DEF_REVEAL_CYCLES,
  parameter int unsigned IDLE_CYCLES     = DEF_IDLE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       clear,
  input  logic       key_start_n,
  input  logic       key_quit_n,
  input  logic       key_sel1_n,
  input  logic       key_sel2_n,
  input  logic       gameOver,
  input  logic [2:0] inGameState,
  output logic       inGameOn,
  output logic       userquit,
  output logic       select1,
  output logic       select2,
  output logic       reveal_busy,
  output logic [7:0] games_played,
  output logic [2:0] sessionState
);

  localparam int unsigned RW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic start_p, quit_p, sel1_p, sel2_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .CLOCK_50(CLOCK_50), .clear(clear), .key_n(key_start_n), .press(start_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_quit (
    .CLOCK_50(CLOCK_50), .clear(clear), .key_n(key_quit_n), .press(quit_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel1 (
    .CLOCK_50(CLOCK_50), .clear(clear), .key_n(key_sel1_n), .press(sel1_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel2 (
    .CLOCK_50(CLOCK_50), .clear(clear), .key_n(key_sel2_n), .press(sel2_p)
  );

  logic [2:0]    state_q, state_d;
  logic          userquit_q, userquit_d;
  logic          sel1_low_q, sel1_low_d;
  logic          sel2_low_q, sel2_low_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [RW-1:0] reveal_q, reveal_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    games_q, games_d;

  logic in_play, pulse_busy, any_p, idle_hit;

  assign in_play    = (state_q == S_PLAY) || (state_q == S_HOLD) || (state_q == S_FIRE);
  assign pulse_busy = sel1_low_q | sel2_low_q;
  assign any_p      = start_p | quit_p | sel1_p | sel2_p;
  assign idle_hit   = in_play && (idle_q == IW'(IDLE_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    userquit_d = 1'b0;
    sel1_low_d = sel1_low_q;
    sel2_low_d = sel2_low_q;
    pulse_d    = pulse_q;
    reveal_d   = reveal_q;
    idle_d     = idle_q;
    games_d    = games_q;

    if (pulse_busy) begin
      if (pulse_q == '0) begin
        sel1_low_d = 1'b0;
        sel2_low_d = 1'b0;
      end else begin
        pulse_d = pulse_q - 1'b1;
      end
    end

    if (in_play) idle_d = any_p ? '0 : idle_q + 1'b1;

    case (state_q)
      S_OFF, S_DONE: begin
        idle_d = '0;
        if (start_p) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (gameOver) begin
          state_d    = S_DONE;
          games_d    = sat_inc8(games_q);
          sel1_low_d = 1'b0;
          sel2_low_d = 1'b0;
          pulse_d    = '0;
        end else if (sel1_p && !pulse_busy) begin
          if (inGameState == IG_TWO_TILE) begin
            state_d  = S_HOLD;
            reveal_d = RW'(REVEAL_CYCLES - 1);
          end else begin
            sel1_low_d = 1'b1;
            pulse_d    = PW'(PULSE_CYCLES - 1);
          end
        end else if (sel2_p && !pulse_busy) begin
          sel2_low_d = 1'b1;
          pulse_d    = PW'(PULSE_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (reveal_q != '0) begin
          reveal_d = reveal_q - 1'b1;
        end else if (!pulse_busy) begin
          state_d    = S_FIRE;
          sel1_low_d = 1'b1;
          pulse_d    = PW'(PULSE_CYCLES - 1);
        end
      end
      S_FIRE: begin
        if (sel1_low_q && (pulse_q == '0)) state_d = S_PLAY;
      end
      default: state_d = S_OFF;
    endcase

    // Quit (key or idle timeout) overrides everything decided above.
    if (in_play && (quit_p || idle_hit)) begin
      state_d    = S_OFF;
      userquit_d = 1'b1;
      sel1_low_d = 1'b0;
      sel2_low_d = 1'b0;
      pulse_d    = '0;
      reveal_d   = '0;
      idle_d     = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      state_q    <= S_OFF;
      userquit_q <= 1'b0;
      sel1_low_q <= 1'b0;
      sel2_low_q <= 1'b0;
      pulse_q    <= '0;
      reveal_q   <= '0;
      idle_q     <= '0;
      games_q    <= '0;
    end else begin
      state_q    <= state_d;
      userquit_q <= userquit_d;
      sel1_low_q <= sel1_low_d;
      sel2_low_q <= sel2_low_d;
      pulse_q    <= pulse_d;
      reveal_q   <= reveal_d;
      idle_q     <= idle_d;
      games_q    <= games_d;
    end
  end

  assign inGameOn     = in_play;
  assign userquit     = userquit_q;
  assign select1      = ~sel1_low_q;
  assign select2      = ~sel2_low_q;
  assign reveal_busy  = (state_q == S_HOLD) || (state_q == S_FIRE);
  assign games_played = games_q;
  assign sessionState = state_q;

endmodule
